idx_stream_ram: RTL
===================

# idx_stream_ram

Banked index RAM with a command-driven streaming read engine. It replaces the single-port combinational index store in the gather path. MMIO software writes one index per cycle. The gather unit issues (base, length) commands and receives NUM_LANES consecutive indices per beat over a valid/ready stream with full backpressure.

## Interface
- ADDR_WIDTH, 10: log2 of total depth; DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 16: index width.
- NUM_LANES, 2: indices per output beat; power of two, 1..8, less than DEPTH.
- clk  in  1  clock, all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- wen  in  1  MMIO write strobe.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- cmd_valid  in  1  stream command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_base  in  ADDR_WIDTH  first index address.
- cmd_len  in  ADDR_WIDTH+1  index count, 0..DEPTH.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  NUM_LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] and holds index at base+beat*NUM_LANES+k.
- out_mask  out  NUM_LANES  per-lane valid; a 0 lane carries zero data.
- out_last  out  1  final beat of the command.
- busy  out  1  command in progress (state != IDLE).

## Operation
- Storage: NUM_LANES banks, each DEPTH/NUM_LANES deep. Address a maps to bank a mod NUM_LANES, row a / NUM_LANES.
- Write: when wen is high, write mem[waddr] at the clock edge. One bank is written. Writes are always accepted, including mid-stream.
- Read: each cycle, lane k's address is computed as (ptr+k) mod DEPTH. Every bank is read in the same cycle. The bank outputs are rotated by ptr mod NUM_LANES into lane order.
- Addressing wraps modulo DEPTH: a base of DEPTH-1 with length 2 returns mem[DEPTH-1], mem[0].
- FSM states are IDLE, FETCH and DRAIN.
  - IDLE: cmd_ready=1. On accept, latch ptr=cmd_base and rem=cmd_len. If cmd_len=0, go to DRAIN with no beats; otherwise go to FETCH.
  - FETCH: issue one read per cycle when a credit is available. After each issue, ptr += NUM_LANES (mod DEPTH) and rem -= min(rem, NUM_LANES). The last issue is tagged last and the FSM moves to DRAIN.
  - DRAIN: wait until the output buffer and in-flight read are empty, then return to IDLE.
- Partial final beat: out_mask[k]=1 only for k < rem at issue time. Masked lanes output 0.
- Output buffer: 2-entry skid buffer. A read may be issued only if buffer occupancy plus the in-flight read is below 2. No beat is ever dropped or duplicated.
- cmd_len=0: busy is high for 1 cycle (DRAIN), then the FSM returns to IDLE. No output beat is produced.
- Same-cycle write and read to the same address: the read returns the old data (read-before-write). A write to an address not yet read in the stream is visible to the stream.
- Commands are not queued; cmd_ready is low outside IDLE.
- Reset mid-stream: the stream is abandoned and all control state clears. Memory contents are retained and are undefined after power-up (no clear).

## Timing
- Reset values: cmd_ready=1, out_valid=0, out_data=0, out_mask=0, out_last=0, busy=0. Internal state: ptr=0, rem=0, FSM=IDLE, buffer empty.
- Command accepted at edge T: first read issues in cycle T+1 and out_valid rises after edge T+2, giving a 2-cycle command-to-data latency.
- With out_ready held high, throughput is one beat per cycle and output beats are contiguous. A command of N indices produces ceil(N/NUM_LANES) beats.
- out_valid, out_data, out_mask and out_last are registered and hold stable while out_valid && !out_ready.
- busy falls in the cycle after the last-beat handshake. cmd_ready rises in the same cycle. A new command may be accepted in that cycle.
- Backpressure release: a beat is presented in the cycle after out_ready is reasserted, with no bubble beyond skid refill.

## Structure
- Package idx_pkg holds:
  - the state typedef (IDLE/FETCH/DRAIN);
  - localparams DEPTH, BANK_DEPTH and LANE_BITS = log2(NUM_LANES), as functions of the parameters.
- Sub-module idx_ram_bank: 1 write port, 1 synchronous read port, with read-before-write. It is instantiated NUM_LANES times.
- The top level contains the address generator, the lane rotator, the FSM, the credit counter and the 2-entry skid buffer.

## Test plan
- Reset then load: write mem[i]=i+0x100 for all i. Send cmd base=3, len=5 with NUM_LANES=2. Expect beats {0x103,0x104}, {0x105,0x106}, {0x107,0}. The final beat has mask=01 and last=1. First out_valid appears 2 cycles after accept.
- Wrap: cmd base=DEPTH-1, len=3. Expect {mem[DEPTH-1],mem[0]}, then {mem[1],0} with mask=01 and last=1.
- Backpressure: len=8 with out_ready toggling in the pattern 1,0,0,1 repeating. Expect exactly 4 beats in order, with data stable while stalled and no drops or duplicates.
- Collision: while streaming, write addr X in the same cycle that X is read. The beat returns the old value. A later write to addr X+4 before it is read returns the new value.
- Edge lengths and reset:
  - len=0 produces no beats, busy high for 1 cycle, and cmd_ready back to 1.
  - len=DEPTH returns all entries once.
  - rstn asserted mid-stream: out_valid=0 and busy=0 immediately, and memory contents are preserved on the next command.

Source files
------------

// File: rtl/idx_pkg.sv
// Shared types and sizing helpers for the banked index RAM and its streaming read engine.
package idx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_LANES_DEF  = 2;

    function automatic int lane_bits_f(input int lanes);
        int b;
        b = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) < lanes) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

    function automatic int depth_f(input int aw);
        return 1 << aw;
    endfunction

    function automatic int bank_depth_f(input int aw, input int lanes);
        return depth_f(aw) / lanes;
    endfunction

    localparam int DEPTH      = depth_f(ADDR_WIDTH_DEF);
    localparam int LANE_BITS  = lane_bits_f(NUM_LANES_DEF);
    localparam int BANK_DEPTH = bank_depth_f(ADDR_WIDTH_DEF, NUM_LANES_DEF);

endpackage

// File: rtl/idx_ram_bank.sv
// One storage bank: single write port plus a registered read port that returns
// the pre-write contents when both ports hit the same row in one cycle.
module idx_ram_bank #(
    parameter int BANK_DEPTH = 512,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(BANK_DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          re,
    input  logic [$clog2(BANK_DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem_r [BANK_DEPTH];

    // Storage array and read register; contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/idx_stream_ram.sv
// Banked index RAM with a (base, length) streaming read engine: one read of
// NUM_LANES consecutive indices per cycle into a 2-entry skid buffer.
module idx_stream_ram
    import idx_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wen,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ADDR_WIDTH-1:0]           cmd_base,
    input  logic [ADDR_WIDTH:0]             cmd_len,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_mask,
    output logic                            out_last,
    output logic                            busy
);

    localparam int LB           = lane_bits_f(NUM_LANES);
    localparam int LBW          = (LB > 0) ? LB : 1;
    localparam int RW           = ADDR_WIDTH - LB;
    localparam int BW           = NUM_LANES * DATA_WIDTH;
    localparam int BANK_DEPTH_L = bank_depth_f(ADDR_WIDTH, NUM_LANES);

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
    logic [ADDR_WIDTH:0]   rem_r, rem_s;
    logic [1:0]            credit_r;
    logic                  issue_s, pop_s, empty_next_s, last_iss_s;
    logic [NUM_LANES-1:0]  mask_s;

    logic                  inf_r, ilast_r;
    logic [LBW-1:0]        rot_r, ptr_lo_s, wbank_s;
    logic [NUM_LANES-1:0]  imask_r;

    logic [RW-1:0]         row_base_s, wrow_s;
    logic [RW-1:0]         rd_row_s [NUM_LANES];
    logic [DATA_WIDTH-1:0] bank_rd_s [NUM_LANES];
    logic [NUM_LANES-1:0]  bank_we_s;
    logic [BW-1:0]         push_data_s;

    logic                  v0_r, v1_r, l0_r, l1_r;
    logic [BW-1:0]         d0_r, d1_r;
    logic [NUM_LANES-1:0]  m0_r, m1_r;

    assign ptr_lo_s   = (LB > 0) ? ptr_r[LBW-1:0] : LBW'(0);
    assign wbank_s    = (LB > 0) ? waddr[LBW-1:0] : LBW'(0);
    assign row_base_s = ptr_r[ADDR_WIDTH-1 -: RW];
    assign wrow_s     = waddr[ADDR_WIDTH-1 -: RW];

    assign pop_s        = v0_r && out_ready;
    assign issue_s      = (state_r == FETCH) && ((credit_r != 2'd0) || pop_s);
    assign empty_next_s = ((credit_r + {1'b0, pop_s}) == 2'd2);
    assign last_iss_s   = (rem_r <= (ADDR_WIDTH+1)'(NUM_LANES));

    // Per-bank row selection and write steering; banks below ptr's lane belong to the next row.
    always_comb begin
        for (int b = 0; b < NUM_LANES; b++) begin
            rd_row_s[b]  = row_base_s + ((LBW'(b) < ptr_lo_s) ? RW'(1) : RW'(0));
            bank_we_s[b] = wen && (wbank_s == LBW'(b));
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            mask_s[k] = (rem_r > (ADDR_WIDTH+1)'(k));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_bank
        idx_ram_bank #(
            .BANK_DEPTH(BANK_DEPTH_L),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we_s[g]),
            .waddr (wrow_s),
            .wdata (wdata),
            .re    (issue_s),
            .raddr (rd_row_s[g]),
            .rdata (bank_rd_s[g])
        );
    end

    // Rotate returned bank words into lane order and zero the lanes past the command end.
    always_comb begin
        push_data_s = {BW{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            push_data_s[k*DATA_WIDTH +: DATA_WIDTH] =
                imask_r[k] ? bank_rd_s[LBW'(rot_r + LBW'(k))] : {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state logic for the command FSM and the address/remaining-count generator.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        rem_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_s   = cmd_base;
                    rem_s   = cmd_len;
                    state_s = (cmd_len == (ADDR_WIDTH+1)'(0)) ? DRAIN : FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (issue_s) begin
                    ptr_s   = ptr_r + ADDR_WIDTH'(NUM_LANES);
                    rem_s   = last_iss_s ? (ADDR_WIDTH+1)'(0) : rem_r - (ADDR_WIDTH+1)'(NUM_LANES);
                    state_s = last_iss_s ? DRAIN : FETCH;
                end else begin
                    state_s = FETCH;
                end
            end
            DRAIN: begin
                if (empty_next_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control registers: FSM, pointer, remaining count, credits and in-flight read tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            ptr_r    <= {ADDR_WIDTH{1'b0}};
            rem_r    <= {(ADDR_WIDTH+1){1'b0}};
            credit_r <= 2'd2;
            inf_r    <= 1'b0;
            rot_r    <= LBW'(0);
            imask_r  <= {NUM_LANES{1'b0}};
            ilast_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            rem_r    <= rem_s;
            credit_r <= credit_r - {1'b0, issue_s} + {1'b0, pop_s};
            inf_r    <= issue_s;
            if (issue_s) begin
                rot_r   <= ptr_lo_s;
                imask_r <= mask_s;
                ilast_r <= last_iss_s;
            end
        end
    end

    // Two-entry skid buffer; entry 0 drives the outputs and is zeroed when empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            d0_r <= {BW{1'b0}};
            d1_r <= {BW{1'b0}};
            m0_r <= {NUM_LANES{1'b0}};
            m1_r <= {NUM_LANES{1'b0}};
            l0_r <= 1'b0;
            l1_r <= 1'b0;
        end else begin
            case ({inf_r, pop_s})
                2'b10: begin
                    if (!v0_r) begin
                        v0_r <= 1'b1;
                        d0_r <= push_data_s;
                        m0_r <= imask_r;
                        l0_r <= ilast_r;
                    end else begin
                        v1_r <= 1'b1;
                        d1_r <= push_data_s;
                        m1_r <= imask_r;
                        l1_r <= ilast_r;
                    end
                end
                2'b01: begin
                    v0_r <= v1_r;
                    d0_r <= d1_r;
                    m0_r <= m1_r;
                    l0_r <= l1_r;
                    v1_r <= 1'b0;
                    d1_r <= {BW{1'b0}};
                    m1_r <= {NUM_LANES{1'b0}};
                    l1_r <= 1'b0;
                end
                2'b11: begin
                    if (v1_r) begin
                        d0_r <= d1_r;
                        m0_r <= m1_r;
                        l0_r <= l1_r;
                        d1_r <= push_data_s;
                        m1_r <= imask_r;
                        l1_r <= ilast_r;
                    end else begin
                        d0_r <= push_data_s;
                        m0_r <= imask_r;
                        l0_r <= ilast_r;
                    end
                end
                default: begin
                    v0_r <= v0_r;
                end
            endcase
        end
    end

    assign out_valid = v0_r;
    assign out_data  = d0_r;
    assign out_mask  = m0_r;
    assign out_last  = l0_r;
    assign busy      = (state_r != IDLE);
    assign cmd_ready = (state_r == IDLE);

endmodule
